// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer. When a solved tour is ready it owns the
// cmd_proc command path, fetches each one-hot move by index and issues it as
// a 2-square leg followed by a 1-square leg, handshaking each command.
module tour_cmd_seq #(
  parameter int unsigned NUM_MOVES    = 24,
  parameter int unsigned FANFARE_MODE = 1,
  parameter logic [7:0]  RESP_DONE    = 8'hA5,
  parameter logic [7:0]  RESP_BUSY    = 8'h5A,
  localparam int unsigned IDX_W       = $clog2(NUM_MOVES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic             abort_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             tour_done,
  output logic             tour_err
);

  localparam logic [3:0] OpMove    = 4'h2;
  localparam logic [3:0] OpMoveFan = 4'h3;
  localparam logic [7:0] HdgN      = 8'h00;
  localparam logic [7:0] HdgW      = 8'h3F;
  localparam logic [7:0] HdgS      = 8'h7F;
  localparam logic [7:0] HdgE      = 8'hBF;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_MOVES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLeg1,
    StLeg1Wt,
    StLeg2,
    StLeg2Wt
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       mv_q, mv_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             last_idx;
  logic             move_onehot;
  logic             fanfare;
  logic [7:0]       hdg1, hdg2;
  logic [15:0]      leg_cmd;

  assign last_idx    = (idx_q == LastIdx);
  assign move_onehot = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);

  // Heading pair for the latched move: first direction travels 2, second 1.
  always_comb begin
    hdg1 = HdgN;
    hdg2 = HdgN;
    unique case (mv_q)
      8'h01:   begin hdg1 = HdgN; hdg2 = HdgW; end
      8'h02:   begin hdg1 = HdgN; hdg2 = HdgE; end
      8'h04:   begin hdg1 = HdgW; hdg2 = HdgN; end
      8'h08:   begin hdg1 = HdgW; hdg2 = HdgS; end
      8'h10:   begin hdg1 = HdgS; hdg2 = HdgW; end
      8'h20:   begin hdg1 = HdgS; hdg2 = HdgE; end
      8'h40:   begin hdg1 = HdgE; hdg2 = HdgS; end
      8'h80:   begin hdg1 = HdgE; hdg2 = HdgN; end
      default: begin hdg1 = HdgN; hdg2 = HdgN; end
    endcase
  end

  // Fanfare opcode selection for the second leg.
  always_comb begin
    fanfare = 1'b0;
    case (FANFARE_MODE)
      1:       fanfare = 1'b1;
      2:       fanfare = last_idx;
      default: fanfare = 1'b0;
    endcase
  end

  // Leg command currently presented; leg 1 is also shown during FETCH.
  always_comb begin
    leg_cmd = {OpMove, hdg1, 4'h2};
    if (state_q == StLeg2 || state_q == StLeg2Wt) begin
      leg_cmd = {(fanfare ? OpMoveFan : OpMove), hdg2, 4'h1};
    end
  end

  // Next-state logic; abort wins over every other event outside IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mv_d    = mv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == StFetch) begin
      mv_d = move;
    end
    if (state_q != StIdle && abort_tour) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_tour && !abort_tour) begin
            state_d = StFetch;
            idx_d   = '0;
          end
        end
        StFetch: begin
          // Check the value being latched so FETCH stays a single cycle.
          if (move_onehot) begin
            state_d = StLeg1;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
        StLeg1:   if (clr_cmd_rdy) state_d = StLeg1Wt;
        StLeg1Wt: if (send_resp)   state_d = StLeg2;
        StLeg2:   if (clr_cmd_rdy) state_d = StLeg2Wt;
        StLeg2Wt: begin
          if (send_resp) begin
            if (last_idx) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StFetch;
              idx_d   = idx_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, index, latched move and status pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      mv_q    <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mv_q    <= mv_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Command path mux and status outputs.
  always_comb begin
    tour_busy = (state_q != StIdle);
    if (tour_busy) begin
      cmd     = leg_cmd;
      cmd_rdy = (state_q == StLeg1) || (state_q == StLeg2);
    end else begin
      cmd     = cmd_UART;
      cmd_rdy = cmd_rdy_UART;
    end
    resp      = (state_q == StLeg2Wt && last_idx) ? RESP_DONE : RESP_BUSY;
    mv_indx   = idx_q;
    tour_done = done_q;
    tour_err  = err_q;
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Bench for tour_cmd_seq: three instances (24 moves fanfare-every, 24 moves
// fanfare-final, 4 moves) driven by a cmd_proc model with a scoreboard queue.
module tb_tour_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [3];
  logic        abort [3];
  logic        clr [3];
  logic        sresp [3];
  logic        cmd_rdy_u [3];
  logic [15:0] cmd_u [3];
  logic [7:0]  move [3];
  logic [15:0] cmd [3];
  logic        cmd_rdy [3];
  logic [7:0]  resp [3];
  logic        busy [3];
  logic        done [3];
  logic        err [3];
  logic [4:0]  idx_a, idx_b;
  logic [1:0]  idx_c;

  logic [7:0]  pat [3];
  logic [4:0]  bad_idx;
  logic [7:0]  bad_val;

  logic [23:0] sb [$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt [3] = '{0, 0, 0};
  int          base;

  always #5 clk = ~clk;

  assign move[0] = (idx_a == bad_idx) ? bad_val : pat[0];
  assign move[1] = pat[1];
  assign move[2] = pat[2];

  tour_cmd_seq #(.NUM_MOVES(24), .FANFARE_MODE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start_tour(start[0]), .abort_tour(abort[0]),
    .move(move[0]), .mv_indx(idx_a), .cmd_UART(cmd_u[0]), .cmd_rdy_UART(cmd_rdy_u[0]),
    .cmd(cmd[0]), .cmd_rdy(cmd_rdy[0]), .clr_cmd_rdy(clr[0]), .send_resp(sresp[0]),
    .resp(resp[0]), .tour_busy(busy[0]), .tour_done(done[0]), .tour_err(err[0])
  );

  tour_cmd_seq #(.NUM_MOVES(24), .FANFARE_MODE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start_tour(start[1]), .abort_tour(abort[1]),
    .move(move[1]), .mv_indx(idx_b), .cmd_UART(cmd_u[1]), .cmd_rdy_UART(cmd_rdy_u[1]),
    .cmd(cmd[1]), .cmd_rdy(cmd_rdy[1]), .clr_cmd_rdy(clr[1]), .send_resp(sresp[1]),
    .resp(resp[1]), .tour_busy(busy[1]), .tour_done(done[1]), .tour_err(err[1])
  );

  tour_cmd_seq #(.NUM_MOVES(4), .FANFARE_MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start_tour(start[2]), .abort_tour(abort[2]),
    .move(move[2]), .mv_indx(idx_c), .cmd_UART(cmd_u[2]), .cmd_rdy_UART(cmd_rdy_u[2]),
    .cmd(cmd[2]), .cmd_rdy(cmd_rdy[2]), .clr_cmd_rdy(clr[2]), .send_resp(sresp[2]),
    .resp(resp[2]), .tour_busy(busy[2]), .tour_done(done[2]), .tour_err(err[2])
  );

  // Count cycles in which each tour_done is high.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] get_idx(input int d);
    if (d == 0) return idx_a;
    if (d == 1) return idx_b;
    return {3'b000, idx_c};
  endfunction

  // Reference leg commands: {leg1, leg2}.
  function automatic logic [31:0] legs(input logic [7:0] m, input int mode, input bit last);
    logic [7:0] a, b;
    logic [3:0] op2;
    case (m)
      8'h01:   begin a = 8'h00; b = 8'h3F; end
      8'h02:   begin a = 8'h00; b = 8'hBF; end
      8'h04:   begin a = 8'h3F; b = 8'h00; end
      8'h08:   begin a = 8'h3F; b = 8'h7F; end
      8'h10:   begin a = 8'h7F; b = 8'h3F; end
      8'h20:   begin a = 8'h7F; b = 8'hBF; end
      8'h40:   begin a = 8'hBF; b = 8'h7F; end
      8'h80:   begin a = 8'hBF; b = 8'h00; end
      default: begin a = 8'h00; b = 8'h00; end
    endcase
    op2 = (mode == 1 || (mode == 2 && last)) ? 4'h3 : 4'h2;
    return {4'h2, a, 4'h2, op2, b, 4'h1};
  endfunction

  task automatic push_moves(input logic [7:0] m, input int mode, input int n_total,
                            input int first, input int count);
    logic [31:0] l;
    for (int i = first; i < first + count; i++) begin
      l = legs(m, mode, i == n_total - 1);
      sb.push_back({l[31:16], 8'h5A});
      sb.push_back({l[15:0], (i == n_total - 1) ? 8'hA5 : 8'h5A});
    end
  endtask

  task automatic start_t(input int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    chk("start_busy", busy[d], 1'b1);
    chk("fetch_no_rdy", cmd_rdy[d], 1'b0);
    chk("start_idx", get_idx(d), 5'd0);
  endtask

  // cmd_proc model: accept each command, then acknowledge it.
  task automatic serve(input int d, input int n);
    logic [23:0] e;
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!cmd_rdy[d] && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) begin
        chk("rdy_timeout", 32'd0, 32'd1);
        return;
      end
      e = sb.pop_front();
      chk("cmd", cmd[d], e[23:8]);
      clr[d] = 1'b1;
      @(negedge clk);
      clr[d] = 1'b0;
      chk("rdy_drop", cmd_rdy[d], 1'b0);
      @(negedge clk);
      chk("resp", resp[d], e[7:0]);
      sresp[d] = 1'b1;
      @(negedge clk);
      sresp[d] = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 0; abort[i] = 0; clr[i] = 0; sresp[i] = 0;
      cmd_rdy_u[i] = 0; cmd_u[i] = 16'h0000; pat[i] = 8'h04;
    end
    bad_idx = 5'd31;
    bad_val = 8'h00;
    cmd_u[0] = 16'hBEEF;
    cmd_rdy_u[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd", cmd[0], 16'hBEEF);
    chk("rst_rdy", cmd_rdy[0], 1'b1);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_resp", resp[0], 8'h5A);
    chk("rst_idx", idx_a, 5'd0);
    chk("rst_done", done[0], 1'b0);
    chk("rst_err", err[0], 1'b0);
    rst_n = 1'b1;

    // UART passthrough with no tour.
    cmd_u[0] = 16'h5000;
    @(negedge clk);
    chk("pass_cmd", cmd[0], 16'h5000);
    chk("pass_rdy", cmd_rdy[0], 1'b1);
    chk("pass_busy", busy[0], 1'b0);
    chk("pass_resp", resp[0], 8'h5A);

    // Full tour, fanfare on every leg 2; UART valid must be ignored.
    push_moves(8'h04, 1, 24, 0, 24);
    start_t(0);
    serve(0, 48);
    @(negedge clk);
    chk("a_done_cnt", done_cnt[0], 1);
    chk("a_idx_end", idx_a, 5'd23);
    chk("a_busy_end", busy[0], 1'b0);
    chk("a_pass_back", cmd[0], 16'h5000);

    // Fanfare on the final move only.
    pat[1] = 8'h01;
    push_moves(8'h01, 2, 24, 0, 24);
    start_t(1);
    serve(1, 48);
    @(negedge clk);
    chk("b_done_cnt", done_cnt[1], 1);
    chk("b_idx_end", idx_b, 5'd23);

    // Illegal move at index 5.
    cmd_rdy_u[0] = 1'b0;
    bad_idx = 5'd5;
    bad_val = 8'h03;
    base = done_cnt[0];
    push_moves(8'h04, 1, 24, 0, 5);
    start_t(0);
    serve(0, 10);
    chk("err_fetch", busy[0], 1'b1);
    @(negedge clk);
    chk("err_pulse", err[0], 1'b1);
    chk("err_busy", busy[0], 1'b0);
    chk("err_rdy", cmd_rdy[0], 1'b0);
    chk("err_idx", idx_a, 5'd5);
    @(negedge clk);
    chk("err_pulse_end", err[0], 1'b0);
    chk("err_no_done", done_cnt[0], base);
    bad_idx = 5'd31;

    // Abort in LEG2 of move 10 together with clr_cmd_rdy.
    push_moves(8'h04, 1, 24, 0, 10);
    sb.push_back({16'h23F2, 8'h5A});
    start_t(0);
    serve(0, 21);
    chk("ab_leg2_rdy", cmd_rdy[0], 1'b1);
    chk("ab_leg2_cmd", cmd[0], 16'h3001);
    cmd_u[0] = 16'h1234;
    cmd_rdy_u[0] = 1'b1;
    abort[0] = 1'b1;
    clr[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    clr[0] = 1'b0;
    chk("ab_busy", busy[0], 1'b0);
    chk("ab_cmd", cmd[0], 16'h1234);
    chk("ab_rdy", cmd_rdy[0], 1'b1);
    chk("ab_idx", idx_a, 5'd10);
    @(negedge clk);
    @(negedge clk);
    chk("ab_no_done", done_cnt[0], base);
    chk("ab_no_err", err[0], 1'b0);
    start_t(0);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("ab2_busy", busy[0], 1'b0);

    // Four-move tour: simultaneous start and abort in IDLE is ignored.
    pat[2] = 8'h10;
    start[2] = 1'b1;
    abort[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    abort[2] = 1'b0;
    chk("c_sa_busy", busy[2], 1'b0);
    @(negedge clk);
    chk("c_sa_busy2", busy[2], 1'b0);
    push_moves(8'h10, 1, 4, 0, 4);
    start_t(2);
    serve(2, 8);
    @(negedge clk);
    chk("c_done_cnt", done_cnt[2], 1);
    chk("c_idx_end", idx_c, 2'd3);
    chk("sb_empty", sb.size(), 0);

    // Asynchronous reset in the middle of a tour.
    start_t(2);
    @(negedge clk);
    chk("c_leg1_rdy", cmd_rdy[2], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy[2], 1'b0);
    chk("rst_mid_rdy", cmd_rdy[2], 1'b0);
    chk("rst_mid_idx", idx_c, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
